sha_work_feeder: RTL
====================

Name: sha_work_feeder

Overview:
Work dispatcher directly upstream of sha_hasher. It latches one work unit: initial digest, midstate, merkle tail, time, target, and nonce range. It then issues one nonce per cycle on sha_hasher's input bus (write_en, digest_intial, digest_in, merkle_in, time_in, target_in, nonce_in). When the range is exhausted it optionally rolls ntime and restarts the range, then signals completion to the host-side controller.

Parameters:
NONCE_STEP, 1, nonce increment per issue; >1 when parallel hashers share a range with interleaved offsets.
MAX_ROLL, 0, number of ntime increments allowed after the first pass over the range.

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
load  in  1  latch the work-unit inputs below and start a job
abort  in  1  stop the current job, return to IDLE
hold  in  1  backpressure; suppresses issue on the edge where it is sampled high
digest_initial_in  in  256  initial digest, added at end of round 63
digest_mid_in  in  256  midstate, clocked ahead one round
merkle_in  in  32  merkle root tail word
time_in  in  32  ntime
target_in  in  32  compact target
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce allowed (inclusive)
write_en  out  1  issue strobe to sha_hasher
digest_intial  out  256  to sha_hasher digest_intial
digest_out  out  256  to sha_hasher digest_in
merkle_out  out  32  to sha_hasher merkle_in
time_out  out  32  current ntime (time_in + roll count)
target_out  out  32  to sha_hasher target_in
nonce_out  out  32  current nonce
busy  out  1  high in RUN
done  out  1  one-cycle pulse at normal completion

Behaviour:
- All outputs are registered. On an edge with RST=1: state IDLE, every output 0, roll counter 0.
- States: IDLE, RUN.
- IDLE:
  - write_en=0, busy=0.
  - load at edge E latches all inputs to the output registers and sets nonce_out=nonce_start, time_out=time_in, roll counter 0, state RUN, write_en=0.
  - If nonce_start > nonce_end at E: no RUN. done=1 after E, state stays IDLE.
- RUN, per edge, priority order: RST, load, abort, hold, issue.
  - load: re-latches as in IDLE; the old job is discarded with no done pulse.
  - abort: state IDLE, write_en=0, no done pulse; data outputs hold their last value.
  - hold=1: write_en=0; nonce_out and time_out unchanged.
  - Issue: write_en=1, with nonce_out/time_out carrying the current values. The internal next-nonce register is then computed as a 33-bit sum nonce+NONCE_STEP.
- The first issue occurs at edge E+1 after load (hold=0). Throughput is 1 issue per cycle while hold=0.
- Exhaustion: true when the 33-bit sum exceeds nonce_end, or bit 32 is set (32-bit wrap). Wrap never reissues a low nonce.
  - roll counter < MAX_ROLL: next issue uses nonce_start, time_out+1 (32-bit modular), roll counter+1. No bubble cycle.
  - Otherwise: the edge after the final issue sets write_en=0, done=1, state IDLE. done clears on the following edge.
- Between issues, data outputs are stable. sha_hasher samples them only when write_en=1.
- done and write_en are never high in the same cycle.
- busy=1 from the edge after load until the edge that raises done or processes abort.

Test Plan:
- Reset: RST=1 for 2 edges with load=1 -> all outputs 0, busy=0; load is ignored.
- Basic range: STEP=1, MAX_ROLL=0, start=0, end=3, time=0x5000_0000.
  - write_en high for 4 consecutive cycles starting edge E+1, nonce_out 0,1,2,3, time constant.
  - done pulses 1 cycle after the last issue, then busy=0.
- Hold: same job with hold=1 on the edges that would issue nonce 2, for 2 edges.
  - write_en low for exactly 2 cycles; sequence 0,1,2,3 is unbroken with no duplicate or skip.
- Roll: MAX_ROLL=1, start=0, end=1, time=0x5000_0000.
  - Issues (0,0x50000000), (1,0x50000000), (0,0x50000001), (1,0x50000001) back-to-back, then done.
- Wrap/step: STEP=4, start=0xFFFF_FFFE, end=0xFFFF_FFFF -> exactly one issue (0xFFFFFFFE), then done.
  - Separately, start=5, end=4 -> no write_en; done pulse after the load edge.
- Abort/preempt:
  - abort after 2 issues -> write_en 0 next cycle, no done, busy=0.
  - load of new work (start=0x100) mid-run -> next issue is 0x100 after one setup cycle; no done for the old job.

Source files
------------

// File: rtl/sha_work_feeder_if.sv
// Work-unit and hasher-issue bus between the host controller, sha_work_feeder and sha_hasher.
// The host side is the master; the feeder is the slave.
interface sha_work_feeder_if;
  logic         load;
  logic         abort;
  logic         hold;
  logic [255:0] digest_initial_in;
  logic [255:0] digest_mid_in;
  logic [31:0]  merkle_in;
  logic [31:0]  time_in;
  logic [31:0]  target_in;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         write_en;
  logic [255:0] digest_intial;
  logic [255:0] digest_out;
  logic [31:0]  merkle_out;
  logic [31:0]  time_out;
  logic [31:0]  target_out;
  logic [31:0]  nonce_out;
  logic         busy;
  logic         done;

  modport master (
    output load, abort, hold, digest_initial_in, digest_mid_in, merkle_in,
           time_in, target_in, nonce_start, nonce_end,
    input  write_en, digest_intial, digest_out, merkle_out, time_out,
           target_out, nonce_out, busy, done
  );

  modport slave (
    input  load, abort, hold, digest_initial_in, digest_mid_in, merkle_in,
           time_in, target_in, nonce_start, nonce_end,
    output write_en, digest_intial, digest_out, merkle_out, time_out,
           target_out, nonce_out, busy, done
  );
endinterface

// File: rtl/sha_work_feeder.sv
// Latches one mining work unit and issues one nonce per cycle to sha_hasher,
// optionally rolling ntime over the range before signalling completion.
module sha_work_feeder #(
  parameter int unsigned NONCE_STEP = 1,
  parameter int unsigned MAX_ROLL   = 0
) (
  input logic               CLK,
  input logic               RST,
  sha_work_feeder_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q;
  logic         write_en_q;
  logic         done_q;
  logic         busy_q;
  logic [255:0] dinit_q;
  logic [255:0] dmid_q;
  logic [31:0]  merkle_q;
  logic [31:0]  target_q;
  logic [31:0]  time_q;
  logic [31:0]  nonce_q;
  logic [31:0]  start_q;
  logic [31:0]  end_q;
  logic [31:0]  nxt_nonce_q;
  logic [31:0]  nxt_time_q;
  logic [31:0]  rolls_left_q;
  logic         last_q;

  logic [32:0]  sum_d;
  logic         exhausted_d;

  // Bit 32 of the sum catches a wrap so a low nonce is never reissued.
  assign sum_d       = {1'b0, nxt_nonce_q} + {1'b0, NONCE_STEP[31:0]};
  assign exhausted_d = sum_d[32] | (sum_d[31:0] > end_q);

  // Job control and issue sequencing; every output comes straight from a register here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      write_en_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      dinit_q      <= 256'd0;
      dmid_q       <= 256'd0;
      merkle_q     <= 32'd0;
      target_q     <= 32'd0;
      time_q       <= 32'd0;
      nonce_q      <= 32'd0;
      start_q      <= 32'd0;
      end_q        <= 32'd0;
      nxt_nonce_q  <= 32'd0;
      nxt_time_q   <= 32'd0;
      rolls_left_q <= 32'd0;
      last_q       <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
      if (bus.load) begin
        dinit_q      <= bus.digest_initial_in;
        dmid_q       <= bus.digest_mid_in;
        merkle_q     <= bus.merkle_in;
        target_q     <= bus.target_in;
        time_q       <= bus.time_in;
        nonce_q      <= bus.nonce_start;
        start_q      <= bus.nonce_start;
        end_q        <= bus.nonce_end;
        nxt_nonce_q  <= bus.nonce_start;
        nxt_time_q   <= bus.time_in;
        rolls_left_q <= MAX_ROLL[31:0];
        last_q       <= 1'b0;
        if (bus.nonce_start > bus.nonce_end) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (bus.abort) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
            end else if (last_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              last_q  <= 1'b0;
            end else if (!bus.hold) begin
              write_en_q <= 1'b1;
              nonce_q    <= nxt_nonce_q;
              time_q     <= nxt_time_q;
              if (!exhausted_d) begin
                nxt_nonce_q <= sum_d[31:0];
              end else if (rolls_left_q != 32'd0) begin
                // Restart the range with the next ntime, back-to-back with no bubble.
                nxt_nonce_q  <= start_q;
                nxt_time_q   <= nxt_time_q + 32'd1;
                rolls_left_q <= rolls_left_q - 32'd1;
              end else begin
                last_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.write_en      = write_en_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.digest_intial = dinit_q;
  assign bus.digest_out    = dmid_q;
  assign bus.merkle_out    = merkle_q;
  assign bus.target_out    = target_q;
  assign bus.time_out      = time_q;
  assign bus.nonce_out     = nonce_q;

endmodule
